// File: rtl/hex_ascii_parser_pkg.sv
// hex_ascii_pkg: ASCII constants, FSM/char-class enums and uppercase fold helper
package hex_ascii_pkg;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_SP    = 8'h20;
    localparam logic [7:0] ASCII_COMMA = 8'h2C;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_UA    = 8'h41;
    localparam logic [7:0] ASCII_LA    = 8'h61;

    typedef enum logic [1:0] {IDLE, ACCUM, SKIP} state_t;
    typedef enum logic [1:0] {CLS_DIGIT, CLS_TERM, CLS_BAD} cls_t;

    function automatic logic [7:0] fold_upper(input logic [7:0] c);
        return (c >= ASCII_LA && c <= ASCII_LA + 8'd5) ? c - 8'h20 : c;
    endfunction
endpackage

// File: rtl/hex_ascii_parser_if.sv
// hex_ascii_parser_if: received-byte strobe and parsed-word valid/ready handshake
interface hex_ascii_parser_if #(
    parameter int WIDTH      = 32,
    parameter int MAX_DIGITS = WIDTH / 4
);
    localparam int CW = $clog2(MAX_DIGITS + 1);
    logic [7:0]       rx_data;
    logic             new_rx_data;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             word_ready;
    logic [CW-1:0]    digit_count;
    modport master (output rx_data, new_rx_data, word_ready, input word_out, word_valid, digit_count);
    modport slave  (input rx_data, new_rx_data, word_ready, output word_out, word_valid, digit_count);
endinterface

// File: rtl/hex_ascii_parser_decode.sv
// hex_char_decode: classifies an ASCII byte as hex digit, terminator or illegal, with its nibble
module hex_char_decode
    import hex_ascii_pkg::*;
(
    input  logic [7:0] rx_data,
    output cls_t       cls,
    output logic [3:0] nibble
);
    logic is_num, is_hex, is_term;
    always_comb begin
        is_num  = rx_data >= ASCII_0 && rx_data <= ASCII_0 + 8'd9;
        is_hex  = (rx_data >= ASCII_UA && rx_data <= ASCII_UA + 8'd5) ||
                  (rx_data >= ASCII_LA && rx_data <= ASCII_LA + 8'd5);
        is_term = rx_data == ASCII_CR || rx_data == ASCII_LF ||
                  rx_data == ASCII_SP || rx_data == ASCII_COMMA;
        cls     = (is_num || is_hex) ? CLS_DIGIT : is_term ? CLS_TERM : CLS_BAD;
        // 'A'/'a' have low nibble 1, so +9 yields 10..15 for both cases
        nibble  = is_num ? rx_data[3:0] : rx_data[3:0] + 4'd9;
    end
endmodule

// File: rtl/hex_ascii_parser.sv
// hex_ascii_parser: ASCII hex byte stream to binary words; HEX_PARSE_ECHO_EN adds a case-folded echo port
module hex_ascii_parser
    import hex_ascii_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MAX_DIGITS = WIDTH / 4
) (
    input  logic              clk,
    input  logic              rst_n,
    hex_ascii_parser_if.slave bus,
    output logic              err_bad_char,
    output logic              err_overflow,
    output logic              err_overrun
`ifdef HEX_PARSE_ECHO_EN
    ,
    output logic [7:0]        echo_data,
    output logic              echo_valid
`endif
);
    localparam int CW = $clog2(MAX_DIGITS + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             publish, bad, ovf, load;
    cls_t             cls;
    logic [3:0]       nibble;

    hex_char_decode u_decode (.rx_data(bus.rx_data), .cls(cls), .nibble(nibble));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        publish = 1'b0;
        bad     = 1'b0;
        ovf     = 1'b0;
        if (bus.new_rx_data) begin
            case (state_q)
                IDLE: begin
                    if (cls == CLS_DIGIT) begin
                        acc_d   = WIDTH'(nibble);
                        cnt_d   = CW'(1);
                        state_d = ACCUM;
                    end else if (cls == CLS_BAD) begin
                        bad     = 1'b1;
                        state_d = SKIP;
                    end
                end
                ACCUM: begin
                    if (cls == CLS_DIGIT && cnt_q == CW'(MAX_DIGITS)) begin
                        ovf     = 1'b1;
                        state_d = SKIP;
                    end else if (cls == CLS_DIGIT) begin
                        acc_d   = (acc_q << 4) | WIDTH'(nibble);
                        cnt_d   = cnt_q + CW'(1);
                    end else if (cls == CLS_TERM) begin
                        publish = 1'b1;
                        state_d = IDLE;
                    end else begin
                        bad     = 1'b1;
                        state_d = SKIP;
                    end
                end
                default: state_d = (cls == CLS_TERM) ? IDLE : SKIP;
            endcase
        end
    end

    // A publish lands if the output slot is empty or being drained in this same cycle
    assign load = publish && (!bus.word_valid || bus.word_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.word_out    <= '0;
            bus.digit_count <= '0;
            bus.word_valid  <= 1'b0;
            err_bad_char    <= 1'b0;
            err_overflow    <= 1'b0;
            err_overrun     <= 1'b0;
        end else begin
            if (load) begin
                bus.word_out    <= acc_q;
                bus.digit_count <= cnt_q;
                bus.word_valid  <= 1'b1;
            end else if (bus.word_valid && bus.word_ready) begin
                bus.word_valid  <= 1'b0;
            end
            err_bad_char <= bad;
            err_overflow <= ovf;
            err_overrun  <= publish && !load;
        end
    end

`ifdef HEX_PARSE_ECHO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_data  <= '0;
            echo_valid <= 1'b0;
        end else begin
            echo_valid <= bus.new_rx_data;
            if (bus.new_rx_data) echo_data <= fold_upper(bus.rx_data);
        end
    end
`endif
endmodule

// File: tb/tb_hex_ascii_parser.sv
// tb_hex_ascii_parser: directed self-checking bench with hand-computed expectations
module tb_hex_ascii_parser;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err_bad_char, err_overflow, err_overrun;
    int   passed = 0;
    int   total = 0;
`ifdef HEX_PARSE_ECHO_EN
    logic [7:0] echo_data;
    logic       echo_valid;
`endif

    hex_ascii_parser_if #(.WIDTH(32)) bus ();

    hex_ascii_parser #(.WIDTH(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave),
        .err_bad_char(err_bad_char),
        .err_overflow(err_overflow),
        .err_overrun(err_overrun)
`ifdef HEX_PARSE_ECHO_EN
        ,
        .echo_data(echo_data),
        .echo_valid(echo_valid)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data     = b;
        bus.new_rx_data = 1'b1;
        @(negedge clk);
        bus.new_rx_data = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    initial begin
        bus.rx_data     = 8'h00;
        bus.new_rx_data = 1'b0;
        bus.word_ready  = 1'b1;
        #12;
        check("rst_valid", {31'b0, bus.word_valid}, 32'd0);
        check("rst_word", bus.word_out, 32'd0);
        check("rst_cnt", {28'b0, bus.digit_count}, 32'd0);
        check("rst_errs", {29'b0, err_bad_char, err_overflow, err_overrun}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        send_str("1F\r");
        check("1f_valid", {31'b0, bus.word_valid}, 32'd1);
        check("1f_word", bus.word_out, 32'h0000001F);
        check("1f_cnt", {28'b0, bus.digit_count}, 32'd2);
        @(negedge clk);
        check("1f_drop", {31'b0, bus.word_valid}, 32'd0);

        send_str("deadBEEF,");
        check("dead_valid", {31'b0, bus.word_valid}, 32'd1);
        check("dead_word", bus.word_out, 32'hDEADBEEF);
        check("dead_cnt", {28'b0, bus.digit_count}, 32'd8);
        send(8'h0A);
        check("lf_no_word", {31'b0, bus.word_valid}, 32'd0);

        send_str("12345678");
        check("ovf_pre", {31'b0, err_overflow}, 32'd0);
        send("9");
        check("ovf_pulse", {31'b0, err_overflow}, 32'd1);
        send(" ");
        check("ovf_clear", {31'b0, err_overflow}, 32'd0);
        check("ovf_no_word", {31'b0, bus.word_valid}, 32'd0);
        send_str("7 ");
        check("7_valid", {31'b0, bus.word_valid}, 32'd1);
        check("7_word", bus.word_out, 32'h00000007);
        check("7_cnt", {28'b0, bus.digit_count}, 32'd1);

        send_str("12G");
        check("bad_pulse", {31'b0, err_bad_char}, 32'd1);
        send_str("4\r");
        check("bad_clear", {31'b0, err_bad_char}, 32'd0);
        check("bad_no_word", {31'b0, bus.word_valid}, 32'd0);
        send_str("AB\r");
        check("ab_valid", {31'b0, bus.word_valid}, 32'd1);
        check("ab_word", bus.word_out, 32'h000000AB);

        @(negedge clk);
        bus.word_ready = 1'b0;
        send_str("1\r");
        check("hold_valid", {31'b0, bus.word_valid}, 32'd1);
        check("hold_word", bus.word_out, 32'h00000001);
        send_str("2\r");
        check("ovr_pulse", {31'b0, err_overrun}, 32'd1);
        check("ovr_word", bus.word_out, 32'h00000001);
        check("ovr_valid", {31'b0, bus.word_valid}, 32'd1);
        @(negedge clk);
        check("ovr_clear", {31'b0, err_overrun}, 32'd0);
        bus.word_ready = 1'b1;
        @(negedge clk);
        check("hs_drop", {31'b0, bus.word_valid}, 32'd0);

        bus.word_ready = 1'b0;
        send_str("3\r4");
        @(negedge clk);
        bus.word_ready  = 1'b1;
        bus.rx_data     = 8'h0D;
        bus.new_rx_data = 1'b1;
        @(negedge clk);
        bus.new_rx_data = 1'b0;
        check("same_valid", {31'b0, bus.word_valid}, 32'd1);
        check("same_word", bus.word_out, 32'h00000004);
        check("same_no_ovr", {31'b0, err_overrun}, 32'd0);
        @(negedge clk);
        check("same_drop", {31'b0, bus.word_valid}, 32'd0);

        bus.word_ready = 1'b0;
        send_str("5\rAB");
        check("pre_rst_valid", {31'b0, bus.word_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'b0, bus.word_valid}, 32'd0);
        check("mid_rst_word", bus.word_out, 32'd0);
        check("mid_rst_cnt", {28'b0, bus.digit_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.word_ready = 1'b1;
        send_str("C\r");
        check("c_valid", {31'b0, bus.word_valid}, 32'd1);
        check("c_word", bus.word_out, 32'h0000000C);
        check("c_cnt", {28'b0, bus.digit_count}, 32'd1);

`ifdef HEX_PARSE_ECHO_EN
        send("a");
        check("echo_valid", {31'b0, echo_valid}, 32'd1);
        check("echo_fold", {24'b0, echo_data}, 32'h41);
        send("G");
        check("echo_pass", {24'b0, echo_data}, 32'h47);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
